// File: rtl/conv1_fmap_pkg.sv
// Shared definitions for the conv1 feature-map writer.
// Holds the frame geometry (14 rows x 7 pixel pairs = 98 beats), the write
// address width, the stored pixel width, the writer FSM state type and the
// packed beat types for the pool input and the memory write data.
package conv1_fmap_pkg;

  localparam int NUM_FILT   = 6;
  localparam int NUM_PXL    = 2;
  localparam int IN_WDTH    = 22;
  localparam int OUT_WDTH   = 8;
  localparam int SHIFT      = 6;
  localparam int FMAP_ROWS  = 14;
  localparam int FMAP_PAIRS = 7;
  localparam int FMAP_BEATS = FMAP_ROWS * FMAP_PAIRS;
  localparam int ADDR_W     = 7;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(FMAP_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } fmap_state_e;

  // [filt][pxl][bit], filter 0 / pixel 0 in the least significant bits
  typedef logic [NUM_FILT-1:0][NUM_PXL-1:0][IN_WDTH-1:0]  pool_beat_t;
  typedef logic [NUM_FILT-1:0][NUM_PXL-1:0][OUT_WDTH-1:0] fmap_beat_t;

endpackage

// File: rtl/conv1_requant.sv
// Single-pixel requantizer: signed pooled value -> unsigned stored byte.
// Arithmetic right shift by SHIFT_R; negative inputs map to 0.
// Build option CONV1_FMAP_SAT_EN: when defined, shifted values above the
// output range clamp to all-ones; otherwise the shifted value is truncated.
// Ports:
//   pxl  in   DATA_W  signed pooled pixel
//   q    out  Q_W     requantized unsigned pixel
module conv1_requant
  import conv1_fmap_pkg::*;
#(
  parameter int DATA_W  = IN_WDTH,
  parameter int Q_W     = OUT_WDTH,
  parameter int SHIFT_R = SHIFT
) (
  input  logic signed [DATA_W-1:0] pxl,
  output logic        [Q_W-1:0]    q
);

  function automatic logic [Q_W-1:0] requant(input logic signed [DATA_W-1:0] v);
    if (v[DATA_W-1]) begin
      return '0;
    end
`ifdef CONV1_FMAP_SAT_EN
    // any set bit between the sign and the kept field means q exceeds range
    if (|v[DATA_W-2:SHIFT_R+Q_W]) begin
      return '1;
    end
`endif
    return Q_W'(v >>> SHIFT_R);
  endfunction

  // dropped fraction bits (and, when truncating, the high bits) are intentional
  logic unused_pxl;
  assign unused_pxl = ^pxl;

  assign q = requant(pxl);

endmodule

// File: rtl/conv1_fmap_writer.sv
// conv1 feature-map writer: consumes pooled beats (6 filters x 2 pixels),
// requantizes each pixel to 8 bits and writes the beat into the conv1
// feature-map memory at beat index row*7 + pair. One 14x14x6 frame is
// collected and held (fmap_done_o) until the conv2 side releases it.
// Build option CONV1_FMAP_SAT_EN selects saturating requantization.
// Ports:
//   conv1_fmap_clk  in   clock
//   conv1_fmap_rst  in   synchronous active-high reset
//   sof_i           in   frame-start pulse
//   pool_valid_i    in   pool_out_i valid
//   pool_out_i      in   packed [filt][pxl][22b] pooled beat
//   fmap_release_i  in   consumer done with the held frame
//   wr_en_o         out  memory write strobe
//   wr_addr_o       out  beat index 0..97
//   wr_data_o       out  packed [filt][pxl][8b] requantized beat
//   fmap_done_o     out  frame complete and held
//   err_o           out  sticky protocol error
module conv1_fmap_writer
  import conv1_fmap_pkg::*;
(
  input  logic                                  conv1_fmap_clk,
  input  logic                                  conv1_fmap_rst,
  input  logic                                  sof_i,
  input  logic                                  pool_valid_i,
  input  logic [NUM_FILT*NUM_PXL*IN_WDTH-1:0]   pool_out_i,
  input  logic                                  fmap_release_i,
  output logic                                  wr_en_o,
  output logic [ADDR_W-1:0]                     wr_addr_o,
  output logic [NUM_FILT*NUM_PXL*OUT_WDTH-1:0]  wr_data_o,
  output logic                                  fmap_done_o,
  output logic                                  err_o
);

  fmap_state_e       state_p0, state_nx;
  logic [ADDR_W-1:0] cnt_p0, cnt_nx;
  logic [ADDR_W-1:0] addr_p0;
  logic              acc_p0;
  logic              err_set_p0;
  pool_beat_t        pool_p0;
  fmap_beat_t        data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  fmap_beat_t        data_p1;
  logic              done_p1;
  logic              err_p1;

  // p0: requantize the incoming beat and decide acceptance
  assign pool_p0 = pool_out_i;

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    for (genvar p = 0; p < NUM_PXL; p++) begin : g_pxl
      conv1_requant #(
        .DATA_W  (IN_WDTH),
        .Q_W     (OUT_WDTH),
        .SHIFT_R (SHIFT)
      ) u_requant (
        .pxl (pool_p0[f][p]),
        .q   (data_p0[f][p])
      );
    end
  end

  always_comb begin
    state_nx   = state_p0;
    cnt_nx     = cnt_p0;
    acc_p0     = 1'b0;
    addr_p0    = cnt_p0;
    err_set_p0 = 1'b0;
    unique case (state_p0)
      ST_IDLE: begin
        if (sof_i) begin
          state_nx = ST_FILL;
          cnt_nx   = '0;
          if (pool_valid_i) begin
            acc_p0  = 1'b1;
            addr_p0 = '0;
            cnt_nx  = ADDR_W'(1);
          end
        end else if (pool_valid_i) begin
          err_set_p0 = 1'b1;
        end
      end
      ST_FILL: begin
        if (sof_i) begin
          // a restart at beat 0 is a clean re-sync, later is a protocol error
          if (cnt_p0 != '0) begin
            err_set_p0 = 1'b1;
          end
          cnt_nx = '0;
          if (pool_valid_i) begin
            acc_p0  = 1'b1;
            addr_p0 = '0;
            cnt_nx  = ADDR_W'(1);
          end
        end else if (pool_valid_i) begin
          acc_p0 = 1'b1;
          if (cnt_p0 == LAST_BEAT) begin
            state_nx = ST_FULL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_p0 + ADDR_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (pool_valid_i) begin
          err_set_p0 = 1'b1;
        end
        if (fmap_release_i) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // p1: registered write port and status
  always_ff @(posedge conv1_fmap_clk) begin
    if (conv1_fmap_rst) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= '0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      cnt_p0   <= cnt_nx;
      vld_p1   <= acc_p0;
      if (acc_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      done_p1  <= (state_nx == ST_FULL);
      err_p1   <= err_p1 | err_set_p0;
    end
  end

  assign wr_en_o     = vld_p1;
  assign wr_addr_o   = addr_p1;
  assign wr_data_o   = data_p1;
  assign fmap_done_o = done_p1;
  assign err_o       = err_p1;

endmodule

// File: tb/tb_conv1_fmap_writer.sv
module tb_conv1_fmap_writer;
  import conv1_fmap_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              sof_i;
  logic              pool_valid_i;
  pool_beat_t        pool_out_i;
  logic              fmap_release_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [95:0]       wr_data_o;
  logic              fmap_done_o;
  logic              err_o;

  conv1_fmap_writer dut (
    .conv1_fmap_clk (clk),
    .conv1_fmap_rst (rst),
    .sof_i          (sof_i),
    .pool_valid_i   (pool_valid_i),
    .pool_out_i     (pool_out_i),
    .fmap_release_i (fmap_release_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .fmap_done_o    (fmap_done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [95:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_writes = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference requantization, integer arithmetic
  function automatic logic [7:0] model_px(input logic [21:0] x);
    int v;
    if (x[21]) return 8'h00;
    v = int'(x) / 64;
`ifdef CONV1_FMAP_SAT_EN
    if (v > 255) return 8'hFF;
`endif
    return 8'(v % 256);
  endfunction

  function automatic logic [95:0] model_beat(input pool_beat_t b);
    fmap_beat_t r;
    for (int f = 0; f < NUM_FILT; f++)
      for (int p = 0; p < NUM_PXL; p++)
        r[f][p] = model_px(b[f][p]);
    return r;
  endfunction

  function automatic pool_beat_t fill_beat(input logic [21:0] x);
    pool_beat_t b;
    for (int f = 0; f < NUM_FILT; f++)
      for (int p = 0; p < NUM_PXL; p++)
        b[f][p] = x;
    return b;
  endfunction

  function automatic pool_beat_t rand_beat();
    pool_beat_t b;
    for (int f = 0; f < NUM_FILT; f++)
      for (int p = 0; p < NUM_PXL; p++)
        b[f][p] = 22'($urandom);
    return b;
  endfunction

  task automatic drive(input logic sof, input logic vld, input logic rel, input pool_beat_t d);
    sof_i          = sof;
    pool_valid_i   = vld;
    fmap_release_i = rel;
    pool_out_i     = d;
    @(posedge clk);
    #1;
    sof_i          = 1'b0;
    pool_valid_i   = 1'b0;
    fmap_release_i = 1'b0;
  endtask

  task automatic send(input logic sof, input logic rel, input pool_beat_t d, input int addr);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = model_beat(d);
    exp_q.push_back(e);
    n_pushed++;
    drive(sof, 1'b1, rel, d);
  endtask

  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", wr_en_o, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr_o, e.addr);
        check("wr_data", wr_data_o, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pool_beat_t bnd;
    logic [31:0] bnd_exp;

    rst = 1'b1;
    sof_i = 1'b0; pool_valid_i = 1'b0; fmap_release_i = 1'b0; pool_out_i = '0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    check("rst_wr_en", wr_en_o, 1'b0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_done", fmap_done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b0;

    // full frame of constant 0x400 pixels
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < FMAP_BEATS; i++) begin
      if (i == FMAP_BEATS - 1) check("done_before_last", fmap_done_o, 1'b0);
      send(1'b0, 1'b0, fill_beat(22'h000400), i);
    end
    check("done_after_last", fmap_done_o, 1'b1);
    check("err_clean_frame", err_o, 1'b0);
    check("fill_bytes", wr_data_o, {12{8'h10}});

    // FULL: beat is dropped, sof ignored, release returns to IDLE
    drive(1'b0, 1'b1, 1'b0, fill_beat(22'h000400));
    check("full_drop_err", err_o, 1'b1);
    check("full_drop_no_wr", wr_en_o, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("full_sof_ignored", fmap_done_o, 1'b1);
    drive(1'b0, 1'b0, 1'b1, '0);
    check("release_done", fmap_done_o, 1'b0);

    // requantization boundary beat, taken with sof in IDLE
    for (int f = 0; f < NUM_FILT; f += 2) begin
      bnd[f][0]   = 22'h3FFFFF;
      bnd[f][1]   = 22'h000000;
      bnd[f+1][0] = 22'h003FC0;
      bnd[f+1][1] = 22'h004000;
    end
`ifdef CONV1_FMAP_SAT_EN
    bnd_exp = 32'hFFFF_0000;
`else
    bnd_exp = 32'h00FF_0000;
`endif
    send(1'b1, 1'b0, bnd, 0);
    check("bnd_bytes", wr_data_o[31:0], bnd_exp);
    check("bnd_addr", wr_addr_o, 0);

    // sof mid-frame restarts at 0; release pulses in IDLE/FILL are ignored
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    check("rst2_err", err_o, 1'b0);
    drive(1'b0, 1'b0, 1'b1, '0);
    send(1'b1, 1'b0, rand_beat(), 0);
    for (int i = 1; i < 40; i++) begin
      if (i == 20) drive(1'b0, 1'b0, 1'b1, '0);
      send(1'b0, (i == 25), rand_beat(), i);
    end
    check("err_before_resync", err_o, 1'b0);
    send(1'b1, 1'b0, rand_beat(), 0);
    check("resync_err", err_o, 1'b1);
    for (int i = 1; i < FMAP_BEATS; i++) begin
      if (i == FMAP_BEATS - 1) check("resync_done_before", fmap_done_o, 1'b0);
      send(1'b0, 1'b0, rand_beat(), i);
    end
    check("resync_done_after", fmap_done_o, 1'b1);
    drive(1'b0, 1'b0, 1'b1, '0);
    check("resync_release", fmap_done_o, 1'b0);

    // reset mid-frame with a beat present; then beat without sof
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    send(1'b1, 1'b0, rand_beat(), 0);
    for (int i = 1; i < 50; i++) send(1'b0, 1'b0, rand_beat(), i);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, rand_beat());
    rst = 1'b0;
    check("midrst_no_wr", wr_en_o, 1'b0);
    check("midrst_err", err_o, 1'b0);
    drive(1'b0, 1'b1, 1'b0, rand_beat());
    check("idle_beat_err", err_o, 1'b1);
    check("idle_beat_no_wr", wr_en_o, 1'b0);
    send(1'b1, 1'b0, rand_beat(), 0);
    check("after_rst_addr", wr_addr_o, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    check("queue_empty", exp_q.size(), 0);
    check("write_count", n_writes, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv1_fmap_writer.md
# conv1_fmap_writer

Downstream consumer of the conv1 pooled stream. Takes each pooled beat (6 filters × 2 pixels × 22 bit), requantizes every pixel to 8 bit and writes the beat into the conv1 feature-map memory at a linear address. It tracks one 14×14×6 frame and holds the frame until the conv2 side releases the buffer. It sits between the conv1 pool output and the conv2 input memory.

## Interface
- NUM_FILT, 6, filters per beat
- NUM_PXL, 2, pooled pixels per filter per beat
- IN_WDTH, 22, pooled operand width (signed)
- OUT_WDTH, 8, stored pixel width (unsigned)
- SHIFT, 6, requantization right shift
- FMAP_BEATS, 98, beats per frame (14 rows × 7 pixel pairs)
- ADDR_W, 7, write address width
- conv1_fmap_clk  in  1  clock; single clock domain
- conv1_fmap_rst  in  1  synchronous, active-high reset
- sof_i  in  1  one-cycle frame-start pulse
- pool_valid_i  in  1  pool_out_i valid this cycle
- pool_out_i  in  NUM_FILT×NUM_PXL×IN_WDTH  packed [filt][pxl][bit]
- fmap_release_i  in  1  consumer has finished with the stored frame
- wr_en_o  out  1  memory write strobe
- wr_addr_o  out  ADDR_W  beat index 0..97 (row×7 + pair)
- wr_data_o  out  NUM_FILT×NUM_PXL×OUT_WDTH  packed [filt][pxl][byte]; pxl 0 is the left column
- fmap_done_o  out  1  frame complete and held
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, FILL, FULL.
- IDLE:
  - sof_i → FILL with beat counter = 0.
  - If sof_i and pool_valid_i occur in the same cycle, the beat is accepted as beat 0 and the counter becomes 1.
  - pool_valid_i without sof_i → dropped, err_o set.
- FILL:
  - Each pool_valid_i writes at the current counter value, then the counter increments.
  - The write of beat 97 → FULL.
  - sof_i with counter ≠ 0 → counter restarts at 0 and err_o is set. If pool_valid_i is high in the same cycle, it is taken as beat 0.
- FULL:
  - fmap_done_o = 1.
  - pool_valid_i → dropped, err_o set.
  - sof_i → ignored.
  - fmap_release_i → IDLE.
- fmap_release_i outside FULL is ignored.
- Requantization per pixel: q = x >>> SHIFT (arithmetic shift).
  - Negative x → 0.
  - Overflow handling is per Configuration.
- err_o clears only on reset.
- Reset mid-frame: state returns to IDLE and the counter goes to 0. Any partially written frame is abandoned, and no write strobe is issued in the reset cycle.
- Reset values: wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0, fmap_done_o = 0, err_o = 0.

## Timing
- All outputs are registered.
- Latency: pool_valid_i accepted at edge N → wr_en_o, wr_addr_o and wr_data_o are valid for exactly the cycle after edge N (1 cycle).
- Back-to-back beats are sustained at 1 per cycle with no bubbles.
- The FULL transition and fmap_done_o rise happen at the same edge as the write strobe for beat 97.
- fmap_done_o falls at the edge that samples fmap_release_i.
- err_o rises one edge after the offending input.

## Configuration
- CONV1_FMAP_SAT_EN
  - Defined: q > 255 saturates to 255.
  - Undefined: q is truncated to bits [SHIFT+7:SHIFT] of x, with no upper clamp; negative x still maps to 0.

## Structure
- Package conv1_fmap_pkg holds:
  - constants for the frame geometry (14, 7, 98), ADDR_W and OUT_WDTH;
  - the FSM state typedef;
  - packed typedefs for the input and output beat.
- One sub-module: conv1_requant. It is a purely combinational single-pixel shift/clamp, instantiated NUM_FILT×NUM_PXL times.

## Test plan
- Reset, then sof_i, then 98 consecutive beats with every pixel = 0x000400 → 98 writes, addresses 0..97, every byte 0x10, fmap_done_o = 1 after the last write, err_o = 0.
- Requantization boundary beat with pixels x = 0x3FFFFF (−1), 0x000000, 0x003FC0, 0x004000:
  - CONV1_FMAP_SAT_EN defined → bytes 0x00, 0x00, 0xFF, 0xFF.
  - CONV1_FMAP_SAT_EN undefined → 0x00, 0x00, 0xFF, 0x00.
- In FULL, drive pool_valid_i → no write and err_o = 1. Then fmap_release_i → IDLE and fmap_done_o = 0. Then sof_i and a beat in the same cycle → write at address 0.
- After 40 beats, assert sof_i → err_o = 1, next write goes to address 0, and the frame then needs 98 more beats to reach FULL.
- Assert reset after 50 beats, then a beat without sof_i → no write and err_o = 1. A following sof_i plus beat → write at address 0.
- fmap_release_i pulsed in IDLE and in FILL → no state change and the write sequence is unaffected.
